// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, with wait states and RV32I extension.
module dmem_responder #(
  parameter int addr_data_width = 32,
  parameter int depth_words     = 256,
  parameter int wait_cycles     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [2:0]                 req_funct3,
  input  logic [addr_data_width-1:0] req_addr,
  input  logic [addr_data_width-1:0] req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [addr_data_width-1:0] rsp_rdata,
  output logic                       rsp_err
);

  localparam int idx_w = $clog2(depth_words);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t                     state;
  logic [3:0]                 wait_cnt;
  logic                       we_q;
  logic [2:0]                 funct3_q;
  logic [idx_w+1:0]           addr_q;
  logic [addr_data_width-1:0] wdata_q;

  logic [addr_data_width-1:0] mem [depth_words];

  logic [idx_w-1:0]           word_idx;
  logic [1:0]                 lane;
  logic [addr_data_width-1:0] shifted;
  logic [addr_data_width-1:0] rd_ext;
  logic [addr_data_width-1:0] wr_word;
  logic [3:0]                 be;
  logic                       legal;
  logic                       misaligned;
  logic                       acc_err;
  logic                       unused_addr_hi;

  assign req_ready      = (state == IDLE);
  assign word_idx       = addr_q[idx_w+1:2];
  assign lane           = addr_q[1:0];
  assign unused_addr_hi = ^req_addr[addr_data_width-1:idx_w+2];

  // Access decode: legality, alignment, lane steering for both loads and stores.
  always_comb begin
    shifted    = mem[word_idx] >> {lane, 3'b000};
    rd_ext     = '0;
    wr_word    = '0;
    be         = 4'b0000;
    misaligned = 1'b0;
    legal      = we_q ? (funct3_q inside {3'b000, 3'b001, 3'b010})
                      : (funct3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    case (funct3_q[1:0])
      2'b00: begin
        be      = 4'b0001 << lane;
        wr_word = {4{wdata_q[7:0]}};
        rd_ext  = {{(addr_data_width-8){~funct3_q[2] & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        misaligned = addr_q[0];
        be         = 4'b0011 << lane;
        wr_word    = {2{wdata_q[15:0]}};
        rd_ext     = {{(addr_data_width-16){~funct3_q[2] & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        misaligned = |addr_q[1:0];
        be         = 4'b1111;
        wr_word    = wdata_q;
        rd_ext     = shifted;
      end
    endcase
    acc_err = ~legal | misaligned;
  end

  // Storage is not reset; a store commits only on the ACCESS edge.
  always_ff @(posedge clk) begin
    if (!reset && state == ACCESS && we_q && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      we_q      <= 1'b0;
      funct3_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[idx_w+1:0];
            wdata_q  <= req_wdata;
            wait_cnt <= 4'(wait_cycles);
            state    <= (wait_cycles > 0) ? WAIT : ACCESS;
          end
        end
        WAIT: begin
          if (wait_cnt <= 4'd1) begin
            wait_cnt <= '0;
            state    <= ACCESS;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ACCESS: begin
          rsp_err   <= acc_err;
          rsp_rdata <= (acc_err || we_q) ? '0 : rd_ext;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: random and directed load/store traffic against a byte-array reference.
module tb_dmem_responder;

  localparam int WAIT_CYC = 2;
  localparam int DEPTH    = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic prev_valid = 1'b0;
  logic random_ready = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  logic [7:0] ref_mem [0:4*DEPTH-1];

  dmem_responder #(
    .addr_data_width(32),
    .depth_words(DEPTH),
    .wait_cycles(WAIT_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_funct3(req_funct3),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (random_ready) begin
      #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: memory as a flat byte array, addresses wrap modulo its size.
  task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int size;
    int base;
    logic legal;
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = we ? (f3 inside {3'b000, 3'b001, 3'b010})
               : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    base  = int'(addr) & (4*DEPTH - 1);
    err   = !legal || (base % size != 0);
    rdata = '0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) ref_mem[base+i] = wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < size; i++) rdata = rdata | (32'(ref_mem[base+i]) << (8*i));
        if (!f3[2] && size < 4 && rdata[8*size-1]) rdata = rdata | (32'hFFFF_FFFF << (8*size));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        if (!prev_valid) checkOutput("latency", 32'(cyc - sb[0].acc_cyc), 32'(WAIT_CYC + 2));
        checkOutput("rsp_rdata", rsp_rdata, sb[0].rdata);
        checkOutput("rsp_err", 32'(rsp_err), 32'(sb[0].err));
        checkOutput("req_ready_in_resp", 32'(req_ready), 32'd0);
        if (rsp_ready) void'(sb.pop_front());
      end
    end
    prev_valid <= rsp_valid;
  end

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic drain);
    exp_t e;
    logic accepted;
    @(posedge clk);
    #1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    accepted   = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (accepted) begin
      model_access(we, f3, addr, wdata, e.rdata, e.err);
      e.acc_cyc = cyc;
      sb.push_back(e);
    end else begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (drain) waitDrain();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    checkOutput({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
  endtask

  initial begin
    logic ok;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkResetOutputs("reset");

    for (int w = 0; w < 16; w++) applyStimulus(1'b1, 3'b010, 32'(4*w), $urandom, 1'b1);

    applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b1);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    applyStimulus(1'b0, 3'b000, 32'h13, 32'h0, 1'b1);
    applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, 1'b1);
    applyStimulus(1'b0, 3'b001, 32'h10, 32'h0, 1'b1);
    applyStimulus(1'b0, 3'b101, 32'h12, 32'h0, 1'b1);
    applyStimulus(1'b1, 3'b000, 32'h11, 32'h55, 1'b1);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    applyStimulus(1'b1, 3'b010, 32'h22, 32'h1234_5678, 1'b1);
    applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 1'b1);
    applyStimulus(1'b0, 3'b001, 32'h21, 32'h0, 1'b1);
    applyStimulus(1'b0, 3'b010, 32'h400, 32'h0, 1'b1);

    // Backpressure: response must hold while rsp_ready is low.
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("bp_rsp_seen", 32'(ok), 32'd1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_idle_req_ready", 32'(req_ready), 32'd1);
    checkOutput("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    waitDrain();

    // Reset during WAIT aborts the store with no write.
    @(posedge clk);
    #1;
    req_we = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 32'h30;
    req_wdata = 32'hCAFE_F00D;
    req_valid = 1'b1;
    @(negedge clk);
    checkOutput("abort_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkResetOutputs("abort");
    applyStimulus(1'b0, 3'b010, 32'h30, 32'h0, 1'b1);

    random_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    $urandom & 32'hFFFF_FC3F, $urandom, 1'b1);
    end
    random_ready = 1'b0;
    @(posedge clk);
    #2 rsp_ready = 1'b1;
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
